pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the stall/flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Covers four hazards: load-use, taken branch resolved in EX, multi-cycle mul/div unit (MDU) and data-memory wait.
- Sits beside the ID/EX register; consumes ID-stage register indices and EX/MEM-stage status.

Parameters:
- MDU_TIMEOUT, 64, max cycles in MDU_BUSY before forced exit with error.
- CNT_W, 32, width of the saturating performance counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset; one clock domain.
- id_rs1  in  5  rs1 index of the instruction in ID.
- id_rs2  in  5  rs2 index of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination of the instruction in EX.
- ex_MemRead  in  1  EX instruction is a load.
- ex_is_muldiv  in  1  EX instruction needs the MDU.
- branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- mdu_done  in  1  MDU result valid this cycle.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  clear IF/ID.
- idex_stall  out  1  hold ID/EX.
- idex_flush  out  1  clear ID/EX (insert bubble).
- exmem_stall  out  1  hold EX/MEM.
- exmem_bubble  out  1  write a NOP into EX/MEM.
- pc_redirect  out  1  PC takes the branch target.
- mdu_start  out  1  one-cycle MDU launch pulse.
- mdu_error  out  1  sticky MDU timeout flag.
- stall_cycles  out  CNT_W  count of cycles with pc_stall=1.
- flush_events  out  CNT_W  count of branch flushes.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, timeout counter=0, mdu_error=0, both perf counters=0.
  - All combinational outputs evaluate to 0 while rst=0.
- Control outputs are combinational from the state and current inputs. State, timeout counter, error flag and perf counters update on the rising clk edge.
- load_use = ex_MemRead && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- mem_wait = mem_req && !mem_ready.
- RUN state, first matching rule wins:
  1. mem_wait: pc_stall, ifid_stall, idex_stall, exmem_stall=1. Next state MEM_HOLD.
  2. branch_taken: pc_redirect, ifid_flush, idex_flush=1; flush_events+1. Next state RUN. Branch wins over a simultaneous load_use or ex_is_muldiv.
  3. ex_is_muldiv: mdu_start=1; pc_stall, ifid_stall, idex_stall, exmem_bubble=1; timeout counter cleared. Next state MDU_BUSY.
  4. load_use: pc_stall, ifid_stall, idex_flush=1 (exactly one bubble). Next state RUN; the next cycle re-evaluates with the load in MEM, so load_use is false.
  5. Otherwise all controls are 0.
- MDU_BUSY state:
  - Outputs: pc_stall, ifid_stall, idex_stall, exmem_bubble=1; mdu_start=0.
  - mdu_done=1 in that cycle: all controls 0 so EX/MEM captures the result. Next state RUN.
  - Otherwise the timeout counter increments. When it reaches MDU_TIMEOUT-1 without done: set mdu_error (sticky until reset); next state RUN.
  - branch_taken is ignored in MDU_BUSY, since EX holds the MDU instruction.
- MEM_HOLD state:
  - Outputs: pc_stall, ifid_stall, idex_stall, exmem_stall=1 while mem_ready=0.
  - Cycle with mem_ready=1: all controls 0. Next state RUN.
  - Other inputs are ignored while in MEM_HOLD.
- Simultaneous events:
  - mem_ready=1 in the same cycle as mem_req=1 in RUN: no wait; fall through to rules 2-5.
  - mdu_done together with the mdu_start cycle is ignored; done is only sampled in MDU_BUSY.
- Perf counters saturate at 2^CNT_W-1; no wrap-around.
- Stall and flush of the same register are never both asserted.
- Reset asserted mid-MDU_BUSY or mid-MEM_HOLD: return to RUN immediately with all outputs 0.

Test Plan:
- Load-use: ex_MemRead=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> for exactly 1 cycle pc_stall=ifid_stall=idex_flush=1; stall_cycles=1. The same stimulus with ex_rd=0 -> no stall.
- Branch during load-use: branch_taken=1 with the load_use condition true -> pc_redirect=ifid_flush=idex_flush=1, pc_stall=0; flush_events=1.
- MDU: ex_is_muldiv=1 for one cycle, mdu_done after 4 busy cycles -> mdu_start pulses once; stalls held for 5 cycles total; stall_cycles=5; back in RUN.
- MDU timeout with MDU_TIMEOUT=8 and mdu_done held 0 -> exit to RUN after 8 busy cycles; mdu_error=1 and it stays 1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> all four stall outputs high for 3 cycles, 0 on the ready cycle; a branch_taken during the hold is ignored.
- Reset mid-MEM_HOLD: drop rst for 1 cycle -> outputs 0 asynchronously, counters 0, state RUN.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage pipeline. It sits beside the
// ID/EX register, looks at the register indices of the instruction in ID and
// at the status of EX/MEM, and drives the hold/clear controls of the PC,
// IF/ID, ID/EX and EX/MEM registers.
//
// Hazards handled (priority order while running normally):
//   1. data-memory wait   : freeze the whole front end and EX/MEM
//   2. taken branch in EX : redirect PC, squash IF/ID and ID/EX
//   3. mul/div in EX      : launch the MDU, freeze the front end, bubble EX/MEM
//   4. load-use           : one-cycle front-end hold with a bubble into ID/EX
//
// Handshake note: mdu_start is a single-cycle launch pulse. The MDU answers
// with mdu_done, which is only looked at while waiting in MDU_BUSY. The data
// memory completes an access in the cycle where mem_req && mem_ready.
//
// Ports
//   clk, rst           : rising-edge clock, asynchronous active-low reset
//   id_rs1/id_rs2      : source indices of the ID instruction
//   id_uses_rs1/rs2    : ID instruction actually reads that source
//   ex_rd, ex_MemRead  : destination / is-load of the EX instruction
//   ex_is_muldiv       : EX instruction needs the MDU
//   branch_taken       : EX resolved a taken branch/jump this cycle
//   mem_req, mem_ready : MEM stage access request / completion
//   mdu_done           : MDU result valid this cycle
//   pc_stall .. mdu_start : pipeline controls, combinational, 0 in reset
//   mdu_error          : sticky MDU timeout flag
//   stall_cycles       : saturating count of cycles with pc_stall=1
//   flush_events       : saturating count of branch flushes
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned MDU_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemRead,
    input  logic             ex_is_muldiv,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             mdu_done,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             exmem_bubble,
    output logic             pc_redirect,
    output logic             mdu_start,
    output logic             mdu_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // Timeout counter only has to reach MDU_TIMEOUT-1.
    localparam int unsigned    TO_W    = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MDU_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_BUSY = 2'd1,
        ST_MEM_HOLD = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             mdu_error_q, mdu_error_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic load_use;
    logic mem_wait;

    always_comb begin
        // x0 is hard-wired to zero, so a load "into" x0 never creates a hazard.
        load_use = ex_MemRead && (ex_rd != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd)));
        // A request that is answered in the same cycle costs nothing.
        mem_wait = mem_req && !mem_ready;
    end

    // ------------------------------------------------------------------
    // Control decode and next-state logic
    // ------------------------------------------------------------------
    logic c_pc_stall;
    logic c_ifid_stall;
    logic c_ifid_flush;
    logic c_idex_stall;
    logic c_idex_flush;
    logic c_exmem_stall;
    logic c_exmem_bubble;
    logic c_pc_redirect;
    logic c_mdu_start;
    logic flush_evt;

    always_comb begin
        c_pc_stall     = 1'b0;
        c_ifid_stall   = 1'b0;
        c_ifid_flush   = 1'b0;
        c_idex_stall   = 1'b0;
        c_idex_flush   = 1'b0;
        c_exmem_stall  = 1'b0;
        c_exmem_bubble = 1'b0;
        c_pc_redirect  = 1'b0;
        c_mdu_start    = 1'b0;
        flush_evt      = 1'b0;
        state_d        = state_q;
        to_cnt_d       = to_cnt_q;
        mdu_error_d    = mdu_error_q;

        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    c_pc_stall    = 1'b1;
                    c_ifid_stall  = 1'b1;
                    c_idex_stall  = 1'b1;
                    c_exmem_stall = 1'b1;
                    state_d       = ST_MEM_HOLD;
                end else if (branch_taken) begin
                    // The wrong-path instructions in IF/ID and ID/EX are
                    // discarded, which also resolves any pending load-use or
                    // mul/div hazard caused by them.
                    c_pc_redirect = 1'b1;
                    c_ifid_flush  = 1'b1;
                    c_idex_flush  = 1'b1;
                    flush_evt     = 1'b1;
                end else if (ex_is_muldiv) begin
                    c_mdu_start    = 1'b1;
                    c_pc_stall     = 1'b1;
                    c_ifid_stall   = 1'b1;
                    c_idex_stall   = 1'b1;
                    c_exmem_bubble = 1'b1;
                    to_cnt_d       = '0;
                    state_d        = ST_MDU_BUSY;
                end else if (load_use) begin
                    // One bubble is enough: next cycle the load sits in MEM
                    // and the forwarding network covers the dependency.
                    c_pc_stall   = 1'b1;
                    c_ifid_stall = 1'b1;
                    c_idex_flush = 1'b1;
                end
            end

            ST_MDU_BUSY: begin
                // branch_taken cannot happen here: EX holds the MDU op.
                if (mdu_done) begin
                    // Release everything so EX/MEM captures the result.
                    state_d = ST_RUN;
                end else begin
                    c_pc_stall     = 1'b1;
                    c_ifid_stall   = 1'b1;
                    c_idex_stall   = 1'b1;
                    c_exmem_bubble = 1'b1;
                    if (to_cnt_q == TO_LAST) begin
                        mdu_error_d = 1'b1;
                        state_d     = ST_RUN;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end

            ST_MEM_HOLD: begin
                // Only mem_ready matters while the memory access is pending.
                if (mem_ready) begin
                    state_d = ST_RUN;
                end else begin
                    c_pc_stall    = 1'b1;
                    c_ifid_stall  = 1'b1;
                    c_idex_stall  = 1'b1;
                    c_exmem_stall = 1'b1;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: forced low while reset is asserted, independent of inputs.
    // ------------------------------------------------------------------
    assign pc_stall     = rst & c_pc_stall;
    assign ifid_stall   = rst & c_ifid_stall;
    assign ifid_flush   = rst & c_ifid_flush;
    assign idex_stall   = rst & c_idex_stall;
    assign idex_flush   = rst & c_idex_flush;
    assign exmem_stall  = rst & c_exmem_stall;
    assign exmem_bubble = rst & c_exmem_bubble;
    assign pc_redirect  = rst & c_pc_redirect;
    assign mdu_start    = rst & c_mdu_start;
    assign mdu_error    = mdu_error_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (c_pc_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_evt && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            to_cnt_q    <= '0;
            mdu_error_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            mdu_error_q <= mdu_error_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed scenarios followed by a randomized run. A behavioural model in the
// bench predicts every control output and counter each cycle.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CW      = 4;
    localparam int CMAX    = 15;

    // Expected control bundle, bit order:
    // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
    //  exmem_stall, exmem_bubble, pc_redirect, mdu_start}
    localparam logic [8:0] C_NONE   = 9'b000000000;
    localparam logic [8:0] C_HOLD4  = 9'b110101000;
    localparam logic [8:0] C_BRANCH = 9'b001010010;
    localparam logic [8:0] C_MDU_GO = 9'b110100101;
    localparam logic [8:0] C_MDU_HD = 9'b110100100;
    localparam logic [8:0] C_LDUSE  = 9'b110010000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_MemRead, ex_is_muldiv;
    logic          branch_taken, mem_req, mem_ready, mdu_done;
    logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic          exmem_stall, exmem_bubble, pc_redirect, mdu_start, mdu_error;
    logic [CW-1:0] stall_cycles, flush_events;
    logic [8:0]    dut_ctrl;

    assign dut_ctrl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                       exmem_stall, exmem_bubble, pc_redirect, mdu_start};

    pipeline_hazard_ctrl #(
        .MDU_TIMEOUT(TIMEOUT),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_MemRead  (ex_MemRead),
        .ex_is_muldiv(ex_is_muldiv),
        .branch_taken(branch_taken),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .mdu_done    (mdu_done),
        .pc_stall    (pc_stall),
        .ifid_stall  (ifid_stall),
        .ifid_flush  (ifid_flush),
        .idex_stall  (idex_stall),
        .idex_flush  (idex_flush),
        .exmem_stall (exmem_stall),
        .exmem_bubble(exmem_bubble),
        .pc_redirect (pc_redirect),
        .mdu_start   (mdu_start),
        .mdu_error   (mdu_error),
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );

    // ---------------- scoreboard counts ----------------
    int checks = 0;
    int errors = 0;

    // ---------------- reference model state ----------------
    bit m_waiting_mdu;   // an MDU operation is outstanding
    bit m_waiting_mem;   // a memory access is outstanding
    int m_busy_spent;    // busy cycles already spent waiting for the MDU
    bit m_err;
    int m_stall;
    int m_flush;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        id_uses_rs1  = 1'b0;
        id_uses_rs2  = 1'b0;
        ex_rd        = 5'd0;
        ex_MemRead   = 1'b0;
        ex_is_muldiv = 1'b0;
        branch_taken = 1'b0;
        mem_req      = 1'b0;
        mem_ready    = 1'b0;
        mdu_done     = 1'b0;
    endtask

    // Called at a falling edge: asserts reset, checks the asynchronous
    // clear, and releases reset at the next falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_ctrl", {23'd0, dut_ctrl}, {23'd0, C_NONE});
        check("rst_stall_cycles", {28'd0, stall_cycles}, 32'd0);
        check("rst_flush_events", {28'd0, flush_events}, 32'd0);
        check("rst_mdu_error", {31'd0, mdu_error}, 32'd0);
        m_waiting_mdu = 1'b0;
        m_waiting_mem = 1'b0;
        m_busy_spent  = 0;
        m_err         = 1'b0;
        m_stall       = 0;
        m_flush       = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle with the inputs currently applied: predict, compare,
    // advance the model across the rising edge.
    task automatic cycle();
        logic [8:0] exp_ctrl;
        bit n_mdu, n_mem, n_err, lu;
        int n_busy;
        exp_ctrl = C_NONE;
        n_mdu    = m_waiting_mdu;
        n_mem    = m_waiting_mem;
        n_busy   = m_busy_spent;
        n_err    = m_err;
        #1;
        lu = ex_MemRead && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        if (m_waiting_mem) begin
            if (mem_ready) n_mem = 1'b0;
            else exp_ctrl = C_HOLD4;
        end else if (m_waiting_mdu) begin
            if (mdu_done) begin
                n_mdu = 1'b0;
            end else begin
                exp_ctrl = C_MDU_HD;
                n_busy   = m_busy_spent + 1;
                if (n_busy == TIMEOUT) begin
                    n_mdu = 1'b0;
                    n_err = 1'b1;
                end
            end
        end else if (mem_req && !mem_ready) begin
            exp_ctrl = C_HOLD4;
            n_mem    = 1'b1;
        end else if (branch_taken) begin
            exp_ctrl = C_BRANCH;
        end else if (ex_is_muldiv) begin
            exp_ctrl = C_MDU_GO;
            n_mdu    = 1'b1;
            n_busy   = 0;
        end else if (lu) begin
            exp_ctrl = C_LDUSE;
        end
        check("ctrl", {23'd0, dut_ctrl}, {23'd0, exp_ctrl});
        check("stall_cycles", {28'd0, stall_cycles}, 32'(m_stall));
        check("flush_events", {28'd0, flush_events}, 32'(m_flush));
        check("mdu_error", {31'd0, mdu_error}, {31'd0, m_err});
        @(posedge clk);
        m_waiting_mdu = n_mdu;
        m_waiting_mem = n_mem;
        m_busy_spent  = n_busy;
        m_err         = n_err;
        if (exp_ctrl[8] && m_stall < CMAX) m_stall++;
        if (exp_ctrl == C_BRANCH && m_flush < CMAX) m_flush++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        do_reset();

        // ---- load-use: exactly one stall cycle ----
        ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        cycle();
        idle();
        cycle();
        check("lu_stall_count", {28'd0, stall_cycles}, 32'd1);
        // same stimulus, destination x0: no stall
        ex_MemRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        cycle();
        idle();
        check("lu_x0_stall_count", {28'd0, stall_cycles}, 32'd1);
        // hazard through rs2
        ex_MemRead = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
        cycle();
        idle();
        cycle();

        // ---- branch beats load-use ----
        do_reset();
        ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        branch_taken = 1'b1;
        cycle();
        idle();
        check("br_flush_count", {28'd0, flush_events}, 32'd1);
        check("br_stall_count", {28'd0, stall_cycles}, 32'd0);

        // ---- MDU with done after 4 busy cycles ----
        do_reset();
        ex_is_muldiv = 1'b1; mdu_done = 1'b1;   // done on launch cycle is ignored
        cycle();
        mdu_done = 1'b0;
        repeat (4) cycle();
        mdu_done = 1'b1;
        cycle();
        idle();
        check("mdu_stall_count", {28'd0, stall_cycles}, 32'd5);
        cycle();

        // ---- MDU timeout ----
        do_reset();
        ex_is_muldiv = 1'b1;
        cycle();
        ex_is_muldiv = 1'b0;
        repeat (TIMEOUT) cycle();
        check("to_error", {31'd0, mdu_error}, 32'd1);
        check("to_stall_count", {28'd0, stall_cycles}, 32'(TIMEOUT + 1));
        repeat (3) cycle();
        check("to_error_sticky", {31'd0, mdu_error}, 32'd1);

        // ---- memory wait, branch ignored during hold ----
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        cycle();
        branch_taken = 1'b1;
        cycle();
        branch_taken = 1'b0;
        cycle();
        mem_ready = 1'b1;
        cycle();
        idle();
        check("mem_stall_count", {28'd0, stall_cycles}, 32'd3);
        check("mem_flush_count", {28'd0, flush_events}, 32'd0);

        // ---- request answered same cycle falls through to branch ----
        mem_req = 1'b1; mem_ready = 1'b1; branch_taken = 1'b1;
        cycle();
        idle();

        // ---- reset in the middle of a memory hold ----
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        cycle();
        cycle();
        do_reset();
        idle();
        branch_taken = 1'b1;   // acted on only if back in normal flow
        cycle();
        idle();
        check("rst_hold_flush", {28'd0, flush_events}, 32'd1);

        // ---- counter saturation through repeated load-use ----
        do_reset();
        ex_MemRead = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        repeat (CMAX + 4) cycle();
        idle();
        check("sat_stall_count", {28'd0, stall_cycles}, 32'(CMAX));

        // ---- randomized run ----
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_uses_rs1  = 1'($urandom_range(0, 1));
            id_uses_rs2  = 1'($urandom_range(0, 1));
            ex_rd        = 5'($urandom_range(0, 3));
            ex_MemRead   = 1'($urandom_range(0, 1));
            ex_is_muldiv = ($urandom_range(0, 7) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            mem_req      = ($urandom_range(0, 3) == 0);
            mem_ready    = 1'($urandom_range(0, 1));
            mdu_done     = ($urandom_range(0, 3) == 0);
            cycle();
        end
        idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
